// File: rtl/vga_csc_out.sv
// vga_csc_out: RGB -> {RGB, YPbPr-601, YPbPr-709, limited RGB} output converter.
// Four-stage pipeline with a fixed latency; de and syncs are delayed to match.
// The requested format is latched only on the vsync leading edge and travels
// down the pipeline with its pixel.
// Optional build macro: VGA_CSC_BLANK_EN (force black while de_i is low).
module vga_csc_out #(
    parameter int unsigned IW     = 8,
    parameter int unsigned OW     = 8,
    parameter logic        VS_POL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode_i,
    input  logic [3*IW-1:0] din,
    input  logic            de_i,
    input  logic            hsync_i,
    input  logic            vsync_i,
    input  logic            csync_i,
    output logic [3*OW-1:0] dout,
    output logic            de_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            csync_o,
    output logic [1:0]      mode_o
);

    typedef enum logic [1:0] {
        MODE_RGB = 2'd0,
        MODE_601 = 2'd1,
        MODE_709 = 2'd2,
        MODE_LIM = 2'd3
    } mode_e;

    // Sum width covers 3 x (OW-bit channel x 12-bit Q10 coefficient) plus rounding.
    localparam int unsigned S  = OW - 8;
    localparam int unsigned SW = OW + 13;

    localparam logic signed [SW-1:0] Y_LO  = SW'(16 << S);
    localparam logic signed [SW-1:0] Y_HI  = SW'(235 << S);
    localparam logic signed [SW-1:0] C_OFF = SW'(128 << S);
    localparam logic signed [SW-1:0] C_HI  = SW'(240 << S);
    localparam logic signed [SW-1:0] RND   = SW'(512);

    // Output lane 2 is the MSB field of dout: R / Pr; lane 1: G / Y; lane 0: B / Pb.
    // Column 0 = R, 1 = G, 2 = B.
    function automatic logic signed [11:0] coef(input mode_e m, input int unsigned lane,
                                                input int unsigned col);
        int r;
        int g;
        int b;
        r = 0;
        g = 0;
        b = 0;
        case (m)
            MODE_601: begin
                case (lane)
                    2: begin r = 450;  g = -377; b = -73; end
                    1: begin r = 263;  g = 516;  b = 100; end
                    0: begin r = -152; g = -298; b = 450; end
                    default: ;
                endcase
            end
            MODE_709: begin
                case (lane)
                    2: begin r = 450;  g = -409; b = -41; end
                    1: begin r = 187;  g = 629;  b = 63;  end
                    0: begin r = -103; g = -347; b = 450; end
                    default: ;
                endcase
            end
            MODE_LIM: begin
                r = (lane == 2) ? 879 : 0;
                g = (lane == 1) ? 879 : 0;
                b = (lane == 0) ? 879 : 0;
            end
            default: ;
        endcase
        return 12'((col == 0) ? r : ((col == 1) ? g : b));
    endfunction

    // Q10 -> integer, add the format offset, clamp to the legal video range.
    function automatic logic [OW-1:0] finish_lane(input logic signed [SW-1:0] sum,
                                                  input logic chroma);
        logic signed [SW-1:0] v;
        logic signed [SW-1:0] hi;
        hi = chroma ? C_HI : Y_HI;
        v  = (sum >>> 10) + (chroma ? C_OFF : Y_LO);
        if (v < Y_LO) begin
            v = Y_LO;
        end else if (v > hi) begin
            v = hi;
        end
        return v[OW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Channel scaling IW -> OW
    // ------------------------------------------------------------------
    logic [IW-1:0] ch_in [3];
    logic [OW-1:0] ch_sc [3];
    logic [OW-1:0] ch_s1 [3];

    for (genvar c = 0; c < 3; c++) begin : g_scale
        assign ch_in[c] = din[(3-c)*IW-1 -: IW];
        if (IW >= OW) begin : g_drop
            assign ch_sc[c] = ch_in[c][IW-1 -: OW];
        end else begin : g_rep
            assign ch_sc[c] = {ch_in[c], ch_in[c][IW-1 -: (OW-IW)]};
        end
`ifdef VGA_CSC_BLANK_EN
        // A zero pixel converts to each format's black level, so blanking
        // only needs to zero the channels ahead of the matrix.
        assign ch_s1[c] = de_i ? ch_sc[c] : '0;
`else
        assign ch_s1[c] = ch_sc[c];
`endif
    end

    // ------------------------------------------------------------------
    // Mode latch
    // ------------------------------------------------------------------
    logic  vs_prev_q;
    mode_e mode_q;
    mode_e mode_eff;
    logic  vs_edge;

    assign vs_edge  = (vsync_i == VS_POL) && (vs_prev_q != VS_POL);
    assign mode_eff = vs_edge ? mode_e'(mode_i) : mode_q;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic signed [SW-1:0] p_d   [3][3];
    logic signed [SW-1:0] p_q   [3][3];
    logic [3*OW-1:0]      raw1_q;
    mode_e                mode1_q;
    logic [3:0]           sy1_q;

    logic signed [SW-1:0] sum_d [3];
    logic signed [SW-1:0] sum_q [3];
    logic [3*OW-1:0]      raw2_q;
    mode_e                mode2_q;
    logic [3:0]           sy2_q;

    logic [OW-1:0]        cl_d  [3];
    logic [OW-1:0]        cl_q  [3];
    logic [3*OW-1:0]      raw3_q;
    mode_e                mode3_q;
    logic [3:0]           sy3_q;

    logic [3*OW-1:0]      dout_q;
    logic [3*OW-1:0]      dout_d;
    logic [3:0]           sy4_q;

    // S1 products: unsigned channel times signed Q10 coefficient
    always_comb begin
        for (int unsigned l = 0; l < 3; l++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                p_d[l][c] = $signed(SW'(ch_s1[c])) * SW'(coef(mode_eff, l, c));
            end
        end
    end

    // S1 register: mode latch, edge history, products and raw pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= mode_e'(mode_i);
            vs_prev_q <= 1'b0;
            for (int unsigned l = 0; l < 3; l++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    p_q[l][c] <= '0;
                end
            end
            raw1_q  <= '0;
            mode1_q <= MODE_RGB;
            sy1_q   <= '0;
        end else begin
            mode_q    <= mode_eff;
            vs_prev_q <= vsync_i;
            p_q       <= p_d;
            raw1_q    <= {ch_s1[0], ch_s1[1], ch_s1[2]};
            mode1_q   <= mode_eff;
            sy1_q     <= {de_i, hsync_i, vsync_i, csync_i};
        end
    end

    // S2 per-lane sums with the rounding constant folded in
    always_comb begin
        for (int unsigned l = 0; l < 3; l++) begin
            sum_d[l] = p_q[l][0] + p_q[l][1] + p_q[l][2] + RND;
        end
    end

    // S2 register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned l = 0; l < 3; l++) begin
                sum_q[l] <= '0;
            end
            raw2_q  <= '0;
            mode2_q <= MODE_RGB;
            sy2_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            raw2_q  <= raw1_q;
            mode2_q <= mode1_q;
            sy2_q   <= sy1_q;
        end
    end

    // S3 shift, offset and clamp; lanes 0/2 are chroma except in limited RGB
    always_comb begin
        for (int unsigned l = 0; l < 3; l++) begin
            cl_d[l] = finish_lane(sum_q[l], (l != 1) && (mode2_q != MODE_LIM));
        end
    end

    // S3 register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned l = 0; l < 3; l++) begin
                cl_q[l] <= '0;
            end
            raw3_q  <= '0;
            mode3_q <= MODE_RGB;
            sy3_q   <= '0;
        end else begin
            cl_q    <= cl_d;
            raw3_q  <= raw2_q;
            mode3_q <= mode2_q;
            sy3_q   <= sy2_q;
        end
    end

    // S4 format select: passthrough uses the scaled input untouched
    always_comb begin
        dout_d = {cl_q[2], cl_q[1], cl_q[0]};
        if (mode3_q == MODE_RGB) begin
            dout_d = raw3_q;
        end
    end

    // S4 output register
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            sy4_q  <= '0;
        end else begin
            dout_q <= dout_d;
            sy4_q  <= sy3_q;
        end
    end

    assign dout    = dout_q;
    assign de_o    = sy4_q[3];
    assign hsync_o = sy4_q[2];
    assign vsync_o = sy4_q[1];
    assign csync_o = sy4_q[0];
    assign mode_o  = mode_q;

endmodule

// File: tb/tb_vga_csc_out.sv
// Self-checking bench for vga_csc_out (IW = OW = 8, active-high vsync).
// Honours VGA_CSC_BLANK_EN the same way the design does.
module tb_vga_csc_out;

    localparam int   IW     = 8;
    localparam int   OW     = 8;
    localparam logic VS_POL = 1'b1;
    localparam int   S      = OW - 8;

    logic            clk;
    logic            reset;
    logic [1:0]      mode_i;
    logic [3*IW-1:0] din;
    logic            de_i, hsync_i, vsync_i, csync_i;
    logic [3*OW-1:0] dout;
    logic            de_o, hsync_o, vsync_o, csync_o;
    logic [1:0]      mode_o;

    vga_csc_out #(.IW(IW), .OW(OW), .VS_POL(VS_POL)) dut (
        .clk(clk), .reset(reset), .mode_i(mode_i), .din(din), .de_i(de_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .csync_i(csync_i),
        .dout(dout), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .csync_o(csync_o), .mode_o(mode_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: latched format, vsync history, 4-deep output delay line.
    logic [1:0]        m_mode;
    logic              m_vsprev;
    logic [3*OW+3:0]   pipe [4];

    int KY [2][3] = '{'{263, 516, 100},  '{187, 629, 63}};
    int KB [2][3] = '{'{-152, -298, 450}, '{-103, -347, 450}};
    int KR [2][3] = '{'{450, -377, -73},  '{450, -409, -41}};

    function automatic int rnd(input int x);
        int t;
        int q;
        t = x + 512;
        q = t / 1024;
        if (t < 0 && (t % 1024) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int clampv(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int scale(input int c);
        if (IW >= OW) return c >> (IW - OW);
        return (c << (OW - IW)) | (c >> (2 * IW - OW));
    endfunction

    function automatic logic [3*OW-1:0] conv(input logic [1:0] m, input logic [3*IW-1:0] px,
                                             input logic blank);
        int ch [3];
        int y, pb, pr, i;
        if (blank) begin
            if (m == 2'd0) return '0;
            if (m == 2'd3) return {3{OW'(16 << S)}};
            return {OW'(128 << S), OW'(16 << S), OW'(128 << S)};
        end
        ch[0] = scale(int'(px[3*IW-1 -: IW]));
        ch[1] = scale(int'(px[2*IW-1 -: IW]));
        ch[2] = scale(int'(px[IW-1:0]));
        if (m == 2'd0) return {OW'(ch[0]), OW'(ch[1]), OW'(ch[2])};
        if (m == 2'd3) begin
            for (int k = 0; k < 3; k++)
                ch[k] = clampv(rnd(879 * ch[k]) + (16 << S), 16 << S, 235 << S);
            return {OW'(ch[0]), OW'(ch[1]), OW'(ch[2])};
        end
        i  = int'(m) - 1;
        y  = clampv(rnd(KY[i][0]*ch[0] + KY[i][1]*ch[1] + KY[i][2]*ch[2]) + (16 << S),
                    16 << S, 235 << S);
        pb = clampv(rnd(KB[i][0]*ch[0] + KB[i][1]*ch[1] + KB[i][2]*ch[2]) + (128 << S),
                    16 << S, 240 << S);
        pr = clampv(rnd(KR[i][0]*ch[0] + KR[i][1]*ch[1] + KR[i][2]*ch[2]) + (128 << S),
                    16 << S, 240 << S);
        return {OW'(pr), OW'(y), OW'(pb)};
    endfunction

    // One clock: capture what the DUT samples, advance the model, land #1 after the edge.
    task automatic tick();
        logic rs, de, hs, vs, cs, blank;
        logic [1:0] m;
        logic [3*IW-1:0] px;
        rs = reset; m = mode_i; px = din; de = de_i; hs = hsync_i; vs = vsync_i; cs = csync_i;
`ifdef VGA_CSC_BLANK_EN
        blank = !de;
`else
        blank = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (rs) begin
            m_mode   = m;
            m_vsprev = 1'b0;
            for (int k = 0; k < 4; k++) pipe[k] = '0;
        end else begin
            if (vs == VS_POL && m_vsprev != VS_POL) m_mode = m;
            m_vsprev = vs;
            for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = {conv(m_mode, px, blank), de, hs, vs, cs};
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Latch a format via a vsync leading edge; the edge cycle carries px/de.
    task automatic latch_mode(input logic [1:0] m, input logic [3*IW-1:0] px, input logic de);
        vsync_i = 1'b0; din = '0; de_i = 1'b0;
        tick();
        vsync_i = 1'b1; mode_i = m; din = px; de_i = de;
        tick();
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] px;
        logic        de;
        logic [23:0] exp;
    } vec_t;

    vec_t tv [12];

    initial begin
        tv[0]  = '{2'd0, 24'h123456, 1'b1, 24'h123456};
        tv[1]  = '{2'd1, 24'hFFFFFF, 1'b1, 24'h80EB80};
        tv[2]  = '{2'd1, 24'hFF0000, 1'b1, 24'hF0515A};
        tv[3]  = '{2'd1, 24'h000000, 1'b1, 24'h801080};
        tv[4]  = '{2'd2, 24'hFFFFFF, 1'b1, 24'h80EB80};
        tv[5]  = '{2'd2, 24'hFF0000, 1'b1, 24'hF03F66};
        tv[6]  = '{2'd3, 24'hFFFFFF, 1'b1, 24'hEBEBEB};
        tv[7]  = '{2'd3, 24'h000000, 1'b1, 24'h101010};
        tv[8]  = '{2'd3, 24'h808080, 1'b1, 24'h7E7E7E};
        tv[9]  = '{2'd2, 24'h000000, 1'b1, 24'h801080};
`ifdef VGA_CSC_BLANK_EN
        tv[10] = '{2'd1, 24'hFF0000, 1'b0, 24'h801080};
        tv[11] = '{2'd0, 24'hA5C3E7, 1'b0, 24'h000000};
`else
        tv[10] = '{2'd1, 24'hFF0000, 1'b0, 24'hF0515A};
        tv[11] = '{2'd0, 24'hA5C3E7, 1'b0, 24'hA5C3E7};
`endif

        reset = 1'b1; mode_i = 2'd2; din = '0; de_i = 1'b0;
        hsync_i = 1'b0; vsync_i = 1'b0; csync_i = 1'b0;
        m_mode = '0; m_vsprev = 1'b0;
        for (int k = 0; k < 4; k++) pipe[k] = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_dout", dout, 0);
        chk("rst_sync", {de_o, hsync_o, vsync_o, csync_o}, 0);
        chk("rst_mode", mode_o, 2);

        // Latency: passthrough pixel and hsync pulse appear four edges later
        reset = 1'b0;
        latch_mode(2'd0, '0, 1'b0);
        chk("mode_latch0", mode_o, 0);
        repeat (4) tick();
        din = 24'h123456; de_i = 1'b1; hsync_i = 1'b1;
        tick();
        din = '0; de_i = 1'b0; hsync_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            chk($sformatf("lat_dout%0d", k), dout, (k == 3) ? 24'h123456 : 24'h0);
            chk($sformatf("lat_de_hs%0d", k), {de_o, hsync_o}, (k == 3) ? 2'b11 : 2'b00);
        end

        // Table of colours, each latched through its own vsync edge
        for (int i = 0; i < 12; i++) begin
            latch_mode(tv[i].mode, tv[i].px, tv[i].de);
            chk($sformatf("tv%0d_mode", i), mode_o, tv[i].mode);
            din = '0; de_i = 1'b0;
            repeat (3) tick();
            chk($sformatf("tv%0d_dout", i), dout, tv[i].exp);
            chk($sformatf("tv%0d_de", i), de_o, tv[i].de);
        end

        // Mode change mid-frame is held until the next leading edge
        latch_mode(2'd0, '0, 1'b0);
        mode_i = 2'd2; din = 24'hFFFFFF; de_i = 1'b1;
        repeat (5) tick();
        chk("sw_hold_mode", mode_o, 0);
        chk("sw_hold_dout", dout, 24'hFFFFFF);
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
        tick();
        chk("sw_new_mode", mode_o, 2);
        din = '0; de_i = 1'b0;
        tick();
        tick();
        chk("sw_last_rgb", dout, 24'hFFFFFF);
        tick();
        chk("sw_first_709", dout, 24'h80EB80);

        // Reset in active video flushes the pipe and reloads the mode
        latch_mode(2'd1, 24'hFFFFFF, 1'b1);
        din = 24'hFFFFFF; de_i = 1'b1;
        repeat (5) tick();
        chk("mid_pre_dout", dout, 24'h80EB80);
        mode_i = 2'd3; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out", {dout, de_o, hsync_o, vsync_o, csync_o}, 0);
        chk("mid_rst_mode", mode_o, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_flush%0d", k), {dout, de_o, hsync_o, vsync_o, csync_o}, 0);
        end
        tick();
        chk("mid_new_dout", dout, 24'hEBEBEB);
        chk("mid_new_de", de_o, 1);

        // Randomised traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            din = (sel == 0) ? 24'h0 : ((sel == 1) ? 24'hFFFFFF : 24'($urandom));
            de_i    = 1'($urandom);
            hsync_i = 1'($urandom);
            csync_i = 1'($urandom);
            if ($urandom_range(0, 29) == 0) vsync_i = ~vsync_i;
            if ($urandom_range(0, 7) == 0) mode_i = 2'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            tick();
            chk("rand", {dout, de_o, hsync_o, vsync_o, csync_o, mode_o}, {pipe[3], m_mode});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
